vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator; successor to the fixed 640x480 controller.
- Timing, sync polarity and framebuffer read latency are set by parameters. Supports a pixel-clock enable.
- Delays sync/valid to line up with pixel data that returns a fixed number of cycles after the address request.
- Sits between the framebuffer (driven by h_addr/v_addr, returns pixel_data) and the VGA pins.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: request counters drive the framebuffer address, and the
// sync/valid bits are delayed by RD_LAT enabled cycles so that they line up with the returning pixel data.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LAT   = 1,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic [23:0]   pixel_data,
    output logic [CW-1:0] h_addr,
    output logic [CW-1:0] v_addr,
    output logic          req_valid,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic          frame_start,
    output logic          line_start
);

    localparam int H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_BEG = H_SYNC + H_BP;
    localparam int V_ACT_BEG = V_SYNC + V_BP;
    localparam int H_ACT_END = H_ACT_BEG + H_ACTIVE;
    localparam int V_ACT_END = V_ACT_BEG + V_ACTIVE;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("vga_timing_gen: RD_LAT must be in 0..4");
    end
    if ((H_TOTAL - 1) > ((1 << CW) - 1) || (V_TOTAL - 1) > ((1 << CW) - 1)) begin : g_bad_cw
        $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [CW-1:0] x_cnt_q, x_cnt_d;
    logic [CW-1:0] y_cnt_q, y_cnt_d;
    logic [31:0]   x_ext, y_ext;
    logic          hs_raw, vs_raw, h_act, v_act;
    logic [2:0]    req_raw, req_dly;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [23:0]   rgb_q, rgb_d;

    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (pix_en) begin
            if (x_cnt_q == H_LAST) begin
                x_cnt_d = '0;
                y_cnt_d = (y_cnt_q == V_LAST) ? '0 : y_cnt_q + CW'(1);
            end else begin
                x_cnt_d = x_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else begin
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
        end
    end

    // Compare in 32 bits so an active-area end equal to 2**CW cannot wrap.
    assign x_ext       = 32'(x_cnt_q);
    assign y_ext       = 32'(y_cnt_q);
    assign hs_raw      = x_ext < H_SYNC;
    assign vs_raw      = y_ext < V_SYNC;
    assign h_act       = (x_ext >= H_ACT_BEG) && (x_ext < H_ACT_END);
    assign v_act       = (y_ext >= V_ACT_BEG) && (y_ext < V_ACT_END);
    assign req_valid   = h_act & v_act;
    assign h_addr      = h_act ? CW'(x_ext - H_ACT_BEG) : '0;
    assign v_addr      = v_act ? CW'(y_ext - V_ACT_BEG) : '0;
    assign frame_start = (x_cnt_q == '0) && (y_cnt_q == '0) && pix_en;
    assign line_start  = (x_cnt_q == '0) && pix_en;
    assign req_raw     = {hs_raw, vs_raw, req_valid};

    if (RD_LAT == 0) begin : g_no_pipe
        assign req_dly = req_raw;
    end else begin : g_pipe
        logic [2:0] pipe_q [RD_LAT];
        logic [2:0] pipe_d [RD_LAT];

        always_comb begin
            for (int i = 0; i < RD_LAT; i++) pipe_d[i] = pipe_q[i];
            if (pix_en) begin
                pipe_d[0] = req_raw;
                for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
            end else begin
                for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
            end
        end

        assign req_dly = pipe_q[RD_LAT-1];
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        rgb_d   = rgb_q;
        if (pix_en) begin
            hsync_d = req_dly[2] ~^ HS_POL;
            vsync_d = req_dly[1] ~^ VS_POL;
            de_d    = req_dly[0];
            rgb_d   = req_dly[0] ? pixel_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign vga_r = rgb_q[23:16];
    assign vga_g = rgb_q[15:8];
    assign vga_b = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster: the driver pushes expected pin values
// derived from raster arithmetic, and a negedge monitor pops and compares them.
module tb_vga_timing_gen;

    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int H_ACTIVE = 10;
    localparam int H_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int V_ACTIVE = 5;
    localparam int V_FP     = 1;
    localparam bit HS_POL   = 1'b1;
    localparam bit VS_POL   = 1'b0;
    localparam int RD_LAT   = 2;
    localparam int CW       = 8;
    localparam int HT       = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT       = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int FRAME    = HT * VT;
    localparam int HB       = H_SYNC + H_BP;
    localparam int VB       = V_SYNC + V_BP;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } out_t;

    logic          clk;
    logic          rst;
    logic          pix_en;
    logic [23:0]   pixel_data;
    logic [CW-1:0] h_addr, v_addr;
    logic          req_valid, hsync, vsync, de, frame_start, line_start;
    logic [7:0]    vga_r, vga_g, vga_b;

    out_t          exp_q[$];
    logic [16:0]   fbq[$];
    int            checks = 0;
    int            errors = 0;
    int            n_en = 0;
    int            seen_en = 0;
    logic          en_at_edge = 1'b0;
    out_t          last_exp;
    out_t          mon_exp;
    int            rp, rx, ry;
    logic          rh_act, rv_act;

    vga_timing_gen #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .RD_LAT(RD_LAT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .pixel_data(pixel_data),
        .h_addr(h_addr), .v_addr(v_addr), .req_valid(req_valid),
        .hsync(hsync), .vsync(vsync), .de(de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .line_start(line_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic out_t reset_out();
        out_t o;
        o.hs  = ~HS_POL;
        o.vs  = ~VS_POL;
        o.de  = 1'b0;
        o.rgb = 24'h0;
        return o;
    endfunction

    // Pin values after the k-th enabled edge show the raster position of request k-RD_LAT.
    function automatic out_t model_out(int k);
        out_t o;
        int   m, p, x, y;
        o = reset_out();
        m = k - RD_LAT;
        if (m >= 0) begin
            p = m % FRAME;
            x = p % HT;
            y = p / HT;
            o.hs = (x < H_SYNC) ? HS_POL : ~HS_POL;
            o.vs = (y < V_SYNC) ? VS_POL : ~VS_POL;
            o.de = (x >= HB) && (x < HB + H_ACTIVE) && (y >= VB) && (y < VB + V_ACTIVE);
            if (o.de) o.rgb = {8'(x - HB), 8'(y - VB), 8'hA5};
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s act=%0h req=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int ncycles, input int en_pct);
        for (int i = 0; i < ncycles; i++) begin
            @(posedge clk);
            #1;
            pix_en = ($urandom_range(99) < en_pct);
            pixel_data = 24'($urandom);
            if (pix_en) begin
                fbq.push_back({req_valid, h_addr, v_addr});
                if (fbq.size() > RD_LAT + 1) void'(fbq.pop_front());
                if (fbq.size() == RD_LAT + 1 && fbq[0][16])
                    pixel_data = {fbq[0][15:8], fbq[0][7:0], 8'hA5};
                exp_q.push_back(model_out(n_en));
                n_en++;
            end
        end
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_en = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            seen_en    = 0;
            en_at_edge = 1'b0;
        end else begin
            en_at_edge = pix_en;
            if (pix_en) seen_en++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            last_exp = reset_out();
            checkOutput("rst_hsync", 32'(hsync), 32'(last_exp.hs));
            checkOutput("rst_vsync", 32'(vsync), 32'(last_exp.vs));
            checkOutput("rst_de", 32'(de), 32'(last_exp.de));
            checkOutput("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(last_exp.rgb));
        end else begin
            if (en_at_edge) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_empty", 32'(0), 32'(1));
                    mon_exp = last_exp;
                end else begin
                    mon_exp = exp_q.pop_front();
                end
            end else begin
                mon_exp = last_exp;
            end
            checkOutput(en_at_edge ? "hsync" : "hold_hsync", 32'(hsync), 32'(mon_exp.hs));
            checkOutput(en_at_edge ? "vsync" : "hold_vsync", 32'(vsync), 32'(mon_exp.vs));
            checkOutput(en_at_edge ? "de" : "hold_de", 32'(de), 32'(mon_exp.de));
            checkOutput(en_at_edge ? "rgb" : "hold_rgb", 32'({vga_r, vga_g, vga_b}), 32'(mon_exp.rgb));
            last_exp = mon_exp;

            rp = seen_en % FRAME;
            rx = rp % HT;
            ry = rp / HT;
            rh_act = (rx >= HB) && (rx < HB + H_ACTIVE);
            rv_act = (ry >= VB) && (ry < VB + V_ACTIVE);
            checkOutput("h_addr", 32'(h_addr), rh_act ? 32'(rx - HB) : 32'(0));
            checkOutput("v_addr", 32'(v_addr), rv_act ? 32'(ry - VB) : 32'(0));
            checkOutput("req_valid", 32'(req_valid), 32'(rh_act && rv_act));
            checkOutput("frame_start", 32'(frame_start), 32'(pix_en && rp == 0));
            checkOutput("line_start", 32'(line_start), 32'(pix_en && rx == 0));
        end
    end

    initial begin
        int waited;
        rst = 1'b0;
        pix_en = 1'b0;
        pixel_data = 24'h0;
        repeat (2) @(posedge clk);
        #1 pix_en = 1'b1;
        @(posedge clk);
        #1 pix_en = 1'b0;
        releaseReset();
        $display("[TB] free-running frames");
        applyStimulus(2 * FRAME + 25, 100);
        $display("[TB] random pixel enable");
        applyStimulus(600, 50);

        $display("[TB] reset during an active line");
        waited = 0;
        while (de !== 1'b1 && waited < 400) begin
            applyStimulus(1, 100);
            waited++;
        end
        if (waited >= 400) checkOutput("wait_de", 32'(de), 32'(1));
        @(posedge clk);
        #3 rst = 1'b0;
        pix_en = 1'b0;
        #1;
        checkOutput("mid_rst_de", 32'(de), 32'(0));
        checkOutput("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(0));
        exp_q.delete();
        fbq.delete();
        n_en = 0;
        repeat (2) @(posedge clk);
        releaseReset();
        applyStimulus(400, 80);
        applyStimulus(FRAME + 10, 100);

        @(posedge clk);
        #1 pix_en = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
